// File: rtl/dispatch_controller_pkg.sv
// Shared definitions for the dispatch controller: ROB index width, recovery
// default, FSM state encoding and small arithmetic helpers.
package oops_structs;

    localparam int ROB_IDX_LEN        = 5;
    localparam int RECOVER_CYCLES_DEF = 2;

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_RECOVER = 1'b1
    } dispatch_state_t;

    // Width of the station select; a single station still needs one select bit.
    function automatic int fu_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dispatch_controller_if.sv
// Handshake bundle between the instruction queue, reservation stations, ROB
// and the dispatch controller.
interface dispatch_controller_if
    import oops_structs::*;
#(
    parameter int NUM_RS = 4
) ();
    localparam int FU_W = fu_width(NUM_RS);

    logic                   flush;
    logic                   iq_vld_i;
    logic                   iq_rdy_o;
    logic [FU_W-1:0]        iq_fu_i;
    logic [ROB_IDX_LEN-1:0] rob_dest_o;
    logic [NUM_RS-1:0]      rs_vld_o;
    logic [NUM_RS-1:0]      rs_rdy_i;
    logic                   rob_alloc_o;
    logic                   rob_commit_i;
    logic [ROB_IDX_LEN:0]   rob_count_o;
    logic [15:0]            stall_cnt_o;

    modport master (
        input  flush, iq_vld_i, iq_fu_i, rs_rdy_i, rob_commit_i,
        output iq_rdy_o, rob_dest_o, rs_vld_o, rob_alloc_o, rob_count_o, stall_cnt_o
    );

    modport slave (
        output flush, iq_vld_i, iq_fu_i, rs_rdy_i, rob_commit_i,
        input  iq_rdy_o, rob_dest_o, rs_vld_o, rob_alloc_o, rob_count_o, stall_cnt_o
    );

endinterface

// File: rtl/dispatch_controller_rob_alloc_counter.sv
// ROB tail pointer and occupancy counter; clear wins over alloc/commit and a
// commit against an empty ROB is dropped.
module rob_alloc_counter #(
    parameter int ROB_DEPTH = 32,
    parameter int IDX_LEN   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               alloc,
    input  logic               commit,
    output logic [IDX_LEN-1:0] tail,
    output logic [IDX_LEN:0]   count,
    output logic               full,
    output logic               empty
);
    localparam logic [IDX_LEN:0]   DEPTH_C = (IDX_LEN+1)'(ROB_DEPTH);
    localparam logic [IDX_LEN-1:0] LAST_C  = IDX_LEN'(ROB_DEPTH - 1);

    logic [IDX_LEN-1:0] tail_r, tail_s;
    logic [IDX_LEN:0]   count_r, count_s;
    logic               dec_s;

    // Next tail/count: tail wraps at ROB_DEPTH, count moves by alloc minus commit.
    always_comb begin
        tail_s  = tail_r;
        count_s = count_r;
        dec_s   = commit && (count_r != '0);
        if (clear) begin
            tail_s  = '0;
            count_s = '0;
        end else begin
            if (alloc) begin
                tail_s = (tail_r == LAST_C) ? '0 : tail_r + IDX_LEN'(1);
            end else begin
                tail_s = tail_r;
            end
            case ({alloc, dec_s})
                2'b10:   count_s = count_r + (IDX_LEN+1)'(1);
                2'b01:   count_s = count_r - (IDX_LEN+1)'(1);
                default: count_s = count_r;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            tail_r  <= tail_s;
            count_r <= count_s;
        end
    end

    assign tail  = tail_r;
    assign count = count_r;
    assign full  = (count_r == DEPTH_C);
    assign empty = (count_r == '0);

endmodule

// File: rtl/dispatch_controller.sv
// Dispatch sequencer: decides when the queue head dispatches, steers it to one
// reservation station, allocates ROB entries and sequences flush recovery.
module dispatch_controller
    import oops_structs::*;
#(
    parameter int NUM_RS         = 4,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF,
    parameter int ROB_DEPTH      = 2**ROB_IDX_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    dispatch_controller_if.master bus
);
    localparam int         FU_W     = fu_width(NUM_RS);
    localparam int         PAD      = 2**FU_W;
    localparam logic [3:0] REC_INIT = 4'(RECOVER_CYCLES - 1);

    dispatch_state_t        state_r, state_s;
    logic [3:0]             rec_cnt_r, rec_cnt_s;
    logic [15:0]            stall_r;
    logic [PAD-1:0]         rdy_pad_s;
    logic                   fu_ok_s, rdy_sel_s, fire_s, full_s, empty_s;
    logic [ROB_IDX_LEN-1:0] tail_s;
    logic [ROB_IDX_LEN:0]   count_s;

    // Fire decision; the padded ready vector keeps out-of-range selects in bounds.
    always_comb begin
        rdy_pad_s               = '0;
        rdy_pad_s[NUM_RS-1:0]   = bus.rs_rdy_i;
        fu_ok_s                 = (32'(bus.iq_fu_i) < 32'(NUM_RS));
        rdy_sel_s               = rdy_pad_s[bus.iq_fu_i];
        fire_s = rst && (state_r == ST_RUN) && !bus.flush && bus.iq_vld_i &&
                 fu_ok_s && rdy_sel_s && !full_s;
    end

    // Next-state logic: flush (re)starts the recovery window from any state.
    always_comb begin
        state_s   = state_r;
        rec_cnt_s = rec_cnt_r;
        if (bus.flush) begin
            state_s   = ST_RECOVER;
            rec_cnt_s = REC_INIT;
        end else begin
            case (state_r)
                ST_RUN: begin
                    state_s = ST_RUN;
                end
                ST_RECOVER: begin
                    if (rec_cnt_r == 4'd0) begin
                        state_s = ST_RUN;
                    end else begin
                        rec_cnt_s = rec_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_s = ST_RUN;
                end
            endcase
        end
    end

    // FSM state and recovery counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_RUN;
            rec_cnt_r <= 4'd0;
        end else begin
            state_r   <= state_s;
            rec_cnt_r <= rec_cnt_s;
        end
    end

    // Stall counter survives flushes; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_r <= 16'd0;
        end else if ((state_r == ST_RUN) && bus.iq_vld_i && !fire_s && !bus.flush) begin
            stall_r <= sat_inc16(stall_r);
        end
    end

    rob_alloc_counter #(
        .ROB_DEPTH (ROB_DEPTH),
        .IDX_LEN   (ROB_IDX_LEN)
    ) u_rob_alloc_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (bus.flush),
        .alloc  (fire_s),
        .commit (bus.rob_commit_i && !empty_s),
        .tail   (tail_s),
        .count  (count_s),
        .full   (full_s),
        .empty  (empty_s)
    );

    assign bus.iq_rdy_o    = fire_s;
    assign bus.rob_alloc_o = fire_s;
    assign bus.rs_vld_o    = fire_s ? (NUM_RS'(1'b1) << bus.iq_fu_i) : '0;
    assign bus.rob_dest_o  = tail_s;
    assign bus.rob_count_o = count_s;
    assign bus.stall_cnt_o = stall_r;

endmodule

// File: tb/tb_dispatch_controller.sv
// Directed bench for dispatch_controller: main instance with 4 stations, a
// second with 3 stations so an out-of-range station select is representable.
module tb_dispatch_controller;
    import oops_structs::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dispatch_controller_if #(.NUM_RS(4)) b0 ();
    dispatch_controller_if #(.NUM_RS(3)) b1 ();

    dispatch_controller #(.NUM_RS(4), .RECOVER_CYCLES(2), .ROB_DEPTH(32)) u0 (
        .clk (clk), .rst (rst), .bus (b0.master));
    dispatch_controller #(.NUM_RS(3), .RECOVER_CYCLES(2), .ROB_DEPTH(32)) u1 (
        .clk (clk), .rst (rst), .bus (b1.master));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rdy"},   32'(b0.iq_rdy_o),    32'd0);
        chk({tag, "_alloc"}, 32'(b0.rob_alloc_o), 32'd0);
        chk({tag, "_rsvld"}, 32'(b0.rs_vld_o),    32'd0);
        chk({tag, "_dest"},  32'(b0.rob_dest_o),  32'd0);
        chk({tag, "_count"}, 32'(b0.rob_count_o), 32'd0);
        chk({tag, "_stall"}, 32'(b0.stall_cnt_o), 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        b0.flush = 1'b0; b0.iq_vld_i = 1'b0; b0.iq_fu_i = 2'd0; b0.rs_rdy_i = 4'b0000; b0.rob_commit_i = 1'b0;
        b1.flush = 1'b0; b1.iq_vld_i = 1'b0; b1.iq_fu_i = 2'd0; b1.rs_rdy_i = 3'b000;  b1.rob_commit_i = 1'b0;
        #12;
        chk_zero("reset");
        tick;
        rst = 1'b1;

        // Five back-to-back dispatches to station 2.
        b0.iq_vld_i = 1'b1; b0.iq_fu_i = 2'd2; b0.rs_rdy_i = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("t1_rsvld", 32'(b0.rs_vld_o), 32'h4);
            chk("t1_dest", 32'(b0.rob_dest_o), 32'(i));
            tick;
        end
        b0.iq_vld_i = 1'b0;
        #2;
        chk("t1_count", 32'(b0.rob_count_o), 32'd5);
        chk("t1_idle_rdy", 32'(b0.iq_rdy_o), 32'd0);

        // Station 1 busy for ten cycles, then released.
        b0.iq_vld_i = 1'b1; b0.iq_fu_i = 2'd1; b0.rs_rdy_i = 4'b1101;
        for (int i = 0; i < 10; i++) begin
            #2;
            chk("stall_rdy", 32'(b0.iq_rdy_o), 32'd0);
            tick;
        end
        #2;
        chk("stall_cnt", 32'(b0.stall_cnt_o), 32'd10);
        b0.rs_rdy_i = 4'b1111;
        #1;
        chk("unstall_rdy", 32'(b0.iq_rdy_o), 32'd1);
        chk("unstall_rsvld", 32'(b0.rs_vld_o), 32'h2);
        chk("unstall_dest", 32'(b0.rob_dest_o), 32'd5);
        tick;

        // Fill to 32 entries, then commit while full: no bypass.
        b0.iq_fu_i = 2'd2;
        for (int i = 0; i < 26; i++) tick;
        #2;
        chk("full_count", 32'(b0.rob_count_o), 32'd32);
        chk("full_rdy", 32'(b0.iq_rdy_o), 32'd0);
        b0.rob_commit_i = 1'b1;
        #1;
        chk("full_commit_rdy", 32'(b0.iq_rdy_o), 32'd0);
        tick;
        b0.rob_commit_i = 1'b0;
        #2;
        chk("after_commit_count", 32'(b0.rob_count_o), 32'd31);
        chk("wrap_dest", 32'(b0.rob_dest_o), 32'd0);
        chk("after_commit_rdy", 32'(b0.iq_rdy_o), 32'd1);
        tick;
        #2;
        chk("refill_count", 32'(b0.rob_count_o), 32'd32);
        chk("refill_dest", 32'(b0.rob_dest_o), 32'd1);
        chk("stall_full", 32'(b0.stall_cnt_o), 32'd11);

        // Flush with a commit in the same cycle; recovery of two cycles.
        b0.flush = 1'b1; b0.rob_commit_i = 1'b1;
        #1;
        chk("flush_rdy", 32'(b0.iq_rdy_o), 32'd0);
        tick;
        b0.flush = 1'b0; b0.rob_commit_i = 1'b0;
        #2;
        chk("rec1_rdy", 32'(b0.iq_rdy_o), 32'd0);
        chk("rec1_count", 32'(b0.rob_count_o), 32'd0);
        chk("rec1_dest", 32'(b0.rob_dest_o), 32'd0);
        tick;
        #2;
        chk("rec2_rdy", 32'(b0.iq_rdy_o), 32'd0);
        tick;
        #2;
        chk("resume_rdy", 32'(b0.iq_rdy_o), 32'd1);
        chk("resume_rsvld", 32'(b0.rs_vld_o), 32'h4);
        tick;
        tick;

        // Flush while firing, then a second flush restarts the window.
        #1;
        chk("prefl_rdy", 32'(b0.iq_rdy_o), 32'd1);
        b0.flush = 1'b1;
        #1;
        chk("flush2_rdy", 32'(b0.iq_rdy_o), 32'd0);
        tick;
        tick;
        b0.flush = 1'b0;
        #2;
        chk("rest1_rdy", 32'(b0.iq_rdy_o), 32'd0);
        tick;
        #2;
        chk("rest2_rdy", 32'(b0.iq_rdy_o), 32'd0);
        tick;
        #2;
        chk("rest3_rdy", 32'(b0.iq_rdy_o), 32'd1);
        chk("rest3_dest", 32'(b0.rob_dest_o), 32'd0);
        chk("rest_stall", 32'(b0.stall_cnt_o), 32'd11);
        tick;

        // Plain commits, commit while empty, commit alongside a fire.
        b0.iq_vld_i = 1'b0; b0.rob_commit_i = 1'b1;
        #2;
        chk("cm_count1", 32'(b0.rob_count_o), 32'd1);
        tick;
        #2;
        chk("cm_count0", 32'(b0.rob_count_o), 32'd0);
        tick;
        #2;
        chk("cm_empty", 32'(b0.rob_count_o), 32'd0);
        b0.rob_commit_i = 1'b0; b0.iq_vld_i = 1'b1;
        tick;
        b0.rob_commit_i = 1'b1;
        tick;
        b0.iq_vld_i = 1'b0; b0.rob_commit_i = 1'b0;
        #2;
        chk("fire_commit_count", 32'(b0.rob_count_o), 32'd1);
        chk("fire_commit_dest", 32'(b0.rob_dest_o), 32'd3);

        // Out-of-range station select on the three-station instance.
        b1.iq_vld_i = 1'b1; b1.iq_fu_i = 2'd3; b1.rs_rdy_i = 3'b111; b1.rob_commit_i = 1'b1;
        #2;
        chk("oor_rdy", 32'(b1.iq_rdy_o), 32'd0);
        chk("oor_rsvld", 32'(b1.rs_vld_o), 32'd0);
        tick;
        #2;
        chk("oor_count", 32'(b1.rob_count_o), 32'd0);
        chk("oor_stall", 32'(b1.stall_cnt_o), 32'd1);
        b1.iq_fu_i = 2'd0; b1.rob_commit_i = 1'b0;
        #1;
        chk("inr_rdy", 32'(b1.iq_rdy_o), 32'd1);
        chk("inr_rsvld", 32'(b1.rs_vld_o), 32'h1);
        tick;
        b1.iq_vld_i = 1'b0;
        #2;
        chk("inr_dest", 32'(b1.rob_dest_o), 32'd1);

        // Asynchronous reset with seven entries in flight.
        b0.iq_vld_i = 1'b1;
        for (int i = 0; i < 6; i++) tick;
        #2;
        chk("pre_rst_count", 32'(b0.rob_count_o), 32'd7);
        rst = 1'b0;
        #1;
        chk_zero("async_rst");
        chk("async_rst_b1", 32'(b1.rob_count_o), 32'd0);
        tick;
        chk_zero("held_rst");
        rst = 1'b1;
        #2;
        chk("post_rst_rdy", 32'(b0.iq_rdy_o), 32'd1);
        chk("post_rst_dest", 32'(b0.rob_dest_o), 32'd0);
        tick;
        b0.iq_vld_i = 1'b0;
        #2;
        chk("post_rst_count", 32'(b0.rob_count_o), 32'd1);
        chk("post_rst_dest1", 32'(b0.rob_dest_o), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dispatch_controller.md
# dispatch_controller

Sequencer between the instruction queue head and the reservation stations. Each cycle it decides whether the queue head can dispatch, allocates the next reorder-buffer (ROB) index, and hands that index to the instruction queue as its destination tag. It routes the handshake to exactly one reservation station and tracks ROB occupancy against retirements. On a pipeline flush it clears allocation state and runs a fixed recovery window before dispatch resumes.

## Interface
Parameters:
- `NUM_RS`, default 4: number of reservation stations, indexed 0..NUM_RS-1.
- `RECOVER_CYCLES`, default 2: dispatch-blocked cycles after a flush; 1..15.
- `ROB_DEPTH`, default 2**ROB_IDX_LEN: number of ROB entries; must be a power of two.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; `rst`=0 resets all state immediately.
- `flush`  in  1  pipeline flush, sampled synchronously.
- `iq_vld_i`  in  1  instruction queue head is valid.
- `iq_rdy_o`  out  1  dispatch accepted this cycle (pops the queue head).
- `iq_fu_i`  in  $clog2(NUM_RS)  target reservation station of the head instruction.
- `rob_dest_o`  out  ROB_IDX_LEN  ROB index for the head instruction; drives the queue's `rob_dest_i`.
- `rs_vld_o`  out  NUM_RS  one-hot write strobe to the reservation stations.
- `rs_rdy_i`  in  NUM_RS  per-station free-slot indication.
- `rob_alloc_o`  out  1  ROB tail write enable.
- `rob_commit_i`  in  1  one ROB entry retired this cycle.
- `rob_count_o`  out  ROB_IDX_LEN+1  current ROB occupancy.
- `stall_cnt_o`  out  16  saturating count of stalled cycles.

## Operation
State machine with two states, RUN and RECOVER. Reset state is RUN.

Internal `fire` signal:
- `fire` = state==RUN && !flush && iq_vld_i && iq_fu_i<NUM_RS && rs_rdy_i[iq_fu_i] && count<ROB_DEPTH.

Outputs (all combinational from registered state and inputs):
- `iq_rdy_o` = `rob_alloc_o` = `fire`.
- `rs_vld_o` = `fire` ? (1<<iq_fu_i) : 0.
- `rob_dest_o` = tail, always driven, including when not firing.
- `rob_count_o` = count.
- `stall_cnt_o` = stall counter.

Register updates, in priority order:
- Flush (`flush`=1):
  - tail <= 0, count <= 0.
  - State <= RECOVER; recover counter <= RECOVER_CYCLES-1.
  - `rob_commit_i` is ignored that cycle.
- RECOVER:
  - No fire.
  - Counter decrements each cycle; when it reaches 0, state <= RUN on that edge.
  - A new flush during RECOVER restarts the window.
- RUN:
  - tail <= (tail + `fire`) mod ROB_DEPTH; wraps from ROB_DEPTH-1 to 0.
  - count <= count + `fire` − (`rob_commit_i` && count!=0).
  - A commit while empty is ignored.
- Full ROB (count==ROB_DEPTH): fire is blocked even if `rob_commit_i`=1 in the same cycle (no commit bypass). Dispatch resumes the next cycle.
- Out-of-range `iq_fu_i`: no fire, head is held, counts as a stall.
- Stall counter: increments when state==RUN && iq_vld_i && !fire && !flush. Saturates at 0xFFFF. Cleared only by reset, not by flush.

## Timing
- Reset values:
  - tail=0, count=0, state=RUN, stall=0.
  - `iq_rdy_o`=0, `rob_alloc_o`=0, `rs_vld_o`=0.
  - `rob_dest_o`=0, `rob_count_o`=0, `stall_cnt_o`=0.
- Deasserting reset mid-operation: first dispatch is possible in the first cycle with `rst`=1.
- Dispatch decision has zero-cycle latency; the tail advance is visible on `rob_dest_o` the cycle after `fire`.
- Sustained throughput: one dispatch per cycle.
- After a flush asserted in cycle N, the earliest fire is cycle N+1+RECOVER_CYCLES.
- The handshake is a single-cycle valid/ready: `iq_rdy_o` never depends on a prior-cycle `iq_vld_i`.

## Structure
- `RECOVER_CYCLES` default and the state enum (`dispatch_state_t`) belong in `oops_structs`.
- `ROB_IDX_LEN` comes from the shared package.
- One natural sub-module, `rob_alloc_counter`: tail pointer plus occupancy counter with wrap and full/empty flags. The FSM and stall counter stay in the top module.

## Test plan
- Reset, then `iq_vld_i`=1, `iq_fu_i`=2, `rs_rdy_i`=4'b1111 for 5 cycles -> `rs_vld_o`=4'b0100 each cycle; `rob_dest_o`=0,1,2,3,4; `rob_count_o`=5.
- Fill ROB (ROB_DEPTH=32) with no commits -> fire stops at count 32. Then apply `rob_commit_i`=1 for one cycle with `iq_vld_i`=1 -> no fire that cycle, count=31. Fire on the next cycle, with `rob_dest_o` wrapped to 0.
- `rs_rdy_i`[1]=0, `iq_fu_i`=1, `iq_vld_i`=1 for 10 cycles -> `iq_rdy_o`=0 throughout, `stall_cnt_o`=10. Raise `rs_rdy_i`[1] -> single fire.
- Flush in cycle 5 while firing, RECOVER_CYCLES=2 -> no fire in cycles 5–7; `rob_count_o`=0 and `rob_dest_o`=0 from cycle 6; fire in cycle 8.
- `iq_fu_i`=NUM_RS, then `rob_commit_i`=1 with count=0 -> no fire, count stays 0, stall increments.
- Assert `rst`=0 mid-stream with count=7 -> all outputs zero immediately, without waiting for a clock edge.
